// File: rtl/uart_word_tx.sv
// uart_word_tx: sends 16-bit words as two UART bytes (low byte first), idle-high line.
// Define UART_TX_PARITY_EN to append an even-parity bit after each data byte (8E1 instead of 8N1).
module uart_word_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] tx_word,
  input  logic        tx_word_valid,
  output logic        tx_word_ready,
  output logic        tx,
  output logic        tx_busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(BAUD_CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit_idx;
  logic             r_byte_hi;
  logic [15:0]      r_hold;
  logic             r_hold_vld;
  logic [15:0]      r_shift;
  logic             r_tx;
`ifdef UART_TX_PARITY_EN
  logic             r_par;
`endif

  logic       w_tick;
  logic       w_load;
  logic [2:0] w_state_nxt;

  assign w_tick = (r_baud == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hold_vld) begin
          w_state_nxt = S_START;
          w_load      = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_tick) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        // Low byte done -> high byte follows; high byte done -> chain a held word with no gap.
        if (w_tick) begin
          if (!r_byte_hi) begin
            w_state_nxt = S_START;
          end else if (r_hold_vld) begin
            w_state_nxt = S_START;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_hi  <= 1'b0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state <= w_state_nxt;

      if (w_tick || (w_state_nxt != r_state) || (w_state_nxt == S_IDLE))
        r_baud <= '0;
      else
        r_baud <= r_baud + CNT_W'(1);

      if (tx_word_valid && !r_hold_vld) begin
        r_hold     <= tx_word;
        r_hold_vld <= 1'b1;
      end else if (w_load) begin
        r_hold_vld <= 1'b0;
      end

      // After the low byte's eight shifts, the high byte sits in r_shift[7:0].
      if (w_load)
        r_shift <= r_hold;
      else if ((r_state == S_DATA) && w_tick)
        r_shift <= {1'b0, r_shift[15:1]};

      if ((r_state == S_DATA) && w_tick)
        r_bit_idx <= r_bit_idx + 3'd1;

      if ((r_state == S_STOP) && w_tick)
        r_byte_hi <= !r_byte_hi;

      case (r_state)
        S_START:  r_tx <= 1'b0;
        S_DATA:   r_tx <= r_shift[0];
`ifdef UART_TX_PARITY_EN
        S_PARITY: r_tx <= r_par;
`endif
        default:  r_tx <= 1'b1;
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_par <= 1'b0;
    else if (r_state == S_START)
      r_par <= 1'b0;
    else if ((r_state == S_DATA) && w_tick)
      r_par <= r_par ^ r_shift[0];
  end
`endif

  assign tx_word_ready = !r_hold_vld;
  assign tx_busy       = (r_state != S_IDLE) | r_hold_vld;
  assign tx            = r_tx;

endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning serial bit rate; BAUD_CNT_MAX = CLK_FREQ/BAUD_RATE (integer division, 5208 at defaults); BAUD_CNT_MAX >= 2 required.
REQ-003 clk  input  1  50 MHz system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tx_word  input  16  data word, e.g. an SDRAM read-FIFO word.
REQ-006 tx_word_valid  input  1  tx_word valid this cycle.
REQ-007 tx_word_ready  output  1  block can accept a word; handshake = valid & ready at a rising edge.
REQ-008 tx  output  1  RS232 serial line, idle high, registered.
REQ-009 tx_busy  output  1  high while any frame is in progress or a word is held.

Function
REQ-010 SHALL contain one 16-bit holding register (hold_vld flag) plus one 16-bit transmit shift path; tx_word_ready = !hold_vld.
REQ-011 On handshake, tx_word SHALL be captured into the holding register and hold_vld set; valid while not ready SHALL be ignored, with no capture and no error.
REQ-012 When the FSM is in IDLE and hold_vld=1, the word SHALL move to the shift path and hold_vld SHALL clear on the same edge; tx_word_ready therefore re-asserts while the word is still being sent.
REQ-013 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-014 Transitions: IDLE->START on load; START->DATA; DATA->STOP after bit 7 (or DATA->PARITY->STOP with macro).
REQ-015 STOP transitions: STOP->START if the low byte was just sent; STOP->START if the high byte was just sent and hold_vld=1 (that word is loaded on this edge); else STOP->IDLE.
REQ-016 Each state/bit SHALL last exactly BAUD_CNT_MAX clk cycles, timed by a baud counter that wraps 0..BAUD_CNT_MAX-1 and resets on every state change.
REQ-017 Frame: start bit 0, data bits LSB first, stop bit 1; low byte tx_word[7:0] first, then high byte tx_word[15:8].
REQ-018 There SHALL be no idle gap between the two bytes of a word, or between back-to-back words.
REQ-019 Latency: with hold empty and FSM IDLE, tx SHALL fall at the second rising edge after the handshake edge.
REQ-020 tx_busy SHALL = (state != IDLE) | hold_vld.
REQ-021 tx SHALL be 1 in IDLE.

Reset
REQ-022 rst_n=0 SHALL immediately force: tx=1, tx_word_ready=1, tx_busy=0, state=IDLE, hold_vld=0, baud counter=0, byte index=low.
REQ-023 Reset mid-frame SHALL abort the frame and discard the held word; after release, no partial frame resumes and tx stays 1 until a new handshake.

Configuration
REQ-024 Macro UART_TX_PARITY_EN: when defined, an even-parity bit (XOR of the 8 data bits) SHALL be inserted after bit 7 in PARITY state, giving 11-bit frames (114576 cycles per word at defaults).
REQ-025 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, giving 10-bit 8N1 frames (104160 cycles per word at defaults).

Verification
REQ-026 Single word 16'hA55A after reset, default parameters, no macro -> tx falls 2 cycles after the handshake; line carries bits 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1, each 5208 cycles; tx_busy drops 104160 cycles after the start edge.
REQ-027 Word 16'h1234 then word 16'h5678 offered immediately -> ready low 1 cycle, second word accepted on the next edge; bytes 34,12,56,78 sent with zero idle gap; ready stays low from the second handshake until the start of its frame.
REQ-028 tx_word_valid held high while ready=0 with a changing tx_word -> only values present at the handshake edges are transmitted, and nothing is duplicated.
REQ-029 rst_n pulsed low mid-DATA of the high byte of 16'hFFFF with a word held -> tx=1 asynchronously, ready=1, busy=0; no further frames follow without a new handshake.
REQ-030 UART_TX_PARITY_EN defined, word 16'h0301 -> low byte parity bit 1, high byte parity bit 0; each frame is 11 bits of 5208 cycles.
REQ-031 CLK_FREQ=1000, BAUD_RATE=250 (BAUD_CNT_MAX=4), word 16'h00FF -> every bit lasts exactly 4 cycles; total 80 cycles.
